// File: rtl/rx_fifo_if.sv
// Receive FIFO bus: engine capture handshake plus host register port.
// The master side drives the engine and host inputs; the FIFO is the slave.
interface rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rxrdy;
    logic [7:0]            uart_data;
    logic                  perr;
    logic                  ferr;
    logic                  ovf;
    logic                  reads0;
    logic                  rd;
    logic                  addr;
    logic [7:0]            dout;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  irq;

    modport master (
        output rxrdy, uart_data, perr, ferr, ovf, rd, addr,
        input  reads0, dout, empty, full, count, irq
    );

    modport slave (
        input  rxrdy, uart_data, perr, ferr, ovf, rd, addr,
        output reads0, dout, empty, full, count, irq
    );
endinterface

// File: rtl/rx_fifo.sv
// Receive FIFO between a UART engine and a host register port.
// Captures one byte plus error flags per rxrdy handshake.
module rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    rx_fifo_if.slave   bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    logic [10:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  drop_q, drop_d;
    logic [7:0]            dout_q, dout_d;
    state_t                state_q;
    logic                  reads0_q;

    logic                  empty;
    logic                  full;
    logic                  cap;
    logic                  push;
    logic                  pop;
    logic                  stat_rd;
    logic [10:0]           head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign cap     = (state_q == IDLE) && bus.rxrdy;
    assign pop     = bus.rd && !bus.addr && !empty;
    // A pop on the same edge frees the slot a full FIFO needs.
    assign push    = cap && (!full || pop);
    assign stat_rd = bus.rd && bus.addr;
    assign head    = empty ? 11'd0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        dout_d  = dout_q;
        if (push) wptr_d = wptr_q + DEPTH_LOG2'(1);
        if (pop)  rptr_d = rptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (stat_rd)     drop_d = 1'b0;
        if (cap && !push) drop_d = 1'b1;
        if (bus.rd) begin
            if (bus.addr)
                dout_d = {drop_q, head[10:8], 2'b00, full, empty};
            else
                dout_d = empty ? 8'h00 : head[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wptr_q] <= {bus.ovf, bus.ferr, bus.perr, bus.uart_data};
    end

    // WAIT holds off recapture until the engine drops rxrdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reads0_q <= 1'b0;
        end else begin
            reads0_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.rxrdy) begin
                        state_q  <= ACK;
                        reads0_q <= 1'b1;
                    end
                end
                ACK: state_q <= WAIT;
                WAIT: begin
                    if (!bus.rxrdy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.reads0 = reads0_q;
    assign bus.dout   = dout_q;
    assign bus.empty  = empty;
    assign bus.full   = full;
    assign bus.count  = count_q;
    assign bus.irq    = !empty || drop_q;
endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: capture handshake, host reads, fill,
// wrap with simultaneous push/pop, held rxrdy and mid-handshake reset.
module tb_rx_fifo;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ack   = 0;

    always #5 clk = ~clk;

    rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(negedge clk) if (bus.reads0 === 1'b1) n_ack++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cap(input logic [7:0] d, input logic o, f, p);
        bit seen = 1'b0;
        bus.rxrdy = 1'b1;
        bus.uart_data = d;
        bus.ovf = o;
        bus.ferr = f;
        bus.perr = p;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.reads0 === 1'b1);
        end
        chk("cap_ack", 32'(seen), 32'd1);
        bus.rxrdy = 1'b0;
        bus.ovf = 1'b0;
        bus.ferr = 1'b0;
        bus.perr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cap_pop(input logic [7:0] d, output logic [7:0] v);
        bus.rxrdy = 1'b1;
        bus.uart_data = d;
        bus.rd = 1'b1;
        bus.addr = 1'b0;
        @(negedge clk);
        v = bus.dout;
        bus.rd = 1'b0;
        chk("pp_ack", 32'(bus.reads0), 32'd1);
        bus.rxrdy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic host_rd(input logic a, output logic [7:0] v);
        bus.rd = 1'b1;
        bus.addr = a;
        @(negedge clk);
        v = bus.dout;
        bus.rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int a0;
        int c0;
        rst = 1'b1;
        bus.rxrdy = 1'b0;
        bus.uart_data = 8'h00;
        bus.perr = 1'b0;
        bus.ferr = 1'b0;
        bus.ovf = 1'b0;
        bus.rd = 1'b0;
        bus.addr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_reads0", 32'(bus.reads0), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // single byte with exact ack latency
        bus.rxrdy = 1'b1;
        bus.uart_data = 8'hA5;
        chk("pre_reads0", 32'(bus.reads0), 32'd0);
        @(negedge clk);
        chk("lat_reads0", 32'(bus.reads0), 32'd1);
        chk("one_count", 32'(bus.count), 32'd1);
        chk("one_irq", 32'(bus.irq), 32'd1);
        @(negedge clk);
        chk("pulse_end", 32'(bus.reads0), 32'd0);
        chk("no_dup", 32'(bus.count), 32'd1);
        bus.rxrdy = 1'b0;
        repeat (2) @(negedge clk);
        host_rd(1'b0, v);
        chk("one_pop", 32'(v), 32'hA5);
        chk("one_empty", 32'(bus.empty), 32'd1);
        chk("one_irq0", 32'(bus.irq), 32'd0);
        @(negedge clk);
        chk("dout_hold", 32'(bus.dout), 32'hA5);
        host_rd(1'b0, v);
        chk("empty_pop", 32'(v), 32'h00);
        chk("empty_cnt", 32'(bus.count), 32'd0);

        // error flags
        cap(8'h3C, 1'b0, 1'b1, 1'b1);
        host_rd(1'b1, v);
        chk("err_stat", 32'(v), 32'h30);
        host_rd(1'b0, v);
        chk("err_pop", 32'(v), 32'h3C);
        host_rd(1'b1, v);
        chk("err_stat2", 32'(v), 32'h01);
        cap(8'h77, 1'b1, 1'b0, 1'b0);
        host_rd(1'b1, v);
        chk("ovf_stat", 32'(v), 32'h40);
        host_rd(1'b0, v);
        chk("ovf_pop", 32'(v), 32'h77);

        // push+pop on empty
        cap_pop(8'h5A, v);
        chk("pp_empty_dout", 32'(v), 32'h00);
        chk("pp_empty_cnt", 32'(bus.count), 32'd1);
        host_rd(1'b0, v);
        chk("pp_empty_pop", 32'(v), 32'h5A);

        // fill and overflow
        for (int i = 0; i < 16; i++) cap(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        cap(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("ovr_count", 32'(bus.count), 32'd16);
        host_rd(1'b1, v);
        chk("ovr_stat", 32'(v), 32'h82);
        host_rd(1'b1, v);
        chk("drop_clr", 32'(v), 32'h02);
        for (int i = 0; i < 16; i++) begin
            host_rd(1'b0, v);
            chk("fill_pop", 32'(v), 32'(i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        host_rd(1'b0, v);
        chk("no_ff", 32'(v), 32'h00);

        // drop set while status read: set wins
        for (int i = 0; i < 16; i++) cap(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        bus.rxrdy = 1'b1;
        bus.uart_data = 8'hEE;
        bus.rd = 1'b1;
        bus.addr = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        chk("race_stat", 32'(bus.dout), 32'h02);
        bus.rxrdy = 1'b0;
        repeat (2) @(negedge clk);
        host_rd(1'b1, v);
        chk("race_drop", 32'(v), 32'h82);
        // full with push+pop: both accepted
        cap_pop(8'hC3, v);
        chk("full_pp_dout", 32'(v), 32'h20);
        chk("full_pp_cnt", 32'(bus.count), 32'd16);
        for (int i = 1; i < 16; i++) begin
            host_rd(1'b0, v);
            chk("full_pp_pop", 32'(v), 32'h20 + 32'(i));
        end
        host_rd(1'b0, v);
        chk("full_pp_last", 32'(v), 32'hC3);

        // wrap with simultaneous push/pop
        for (int i = 0; i < 8; i++) cap(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cap_pop(8'h50 + 8'(i), v);
            if (i < 8) chk("wrap_pop", 32'(v), 32'h40 + 32'(i));
            else       chk("wrap_pop", 32'(v), 32'h50 + 32'(i - 8));
            chk("wrap_cnt", 32'(bus.count), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            host_rd(1'b0, v);
            chk("wrap_drain", 32'(v), 32'h70 + 32'(i));
        end

        // rxrdy held high
        a0 = n_ack;
        c0 = 32'(bus.count);
        bus.rxrdy = 1'b1;
        bus.uart_data = 8'h99;
        repeat (10) @(negedge clk);
        bus.rxrdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_push", 32'(bus.count), 32'(c0 + 1));
        chk("hold_ack", 32'(n_ack - a0), 32'd1);
        host_rd(1'b0, v);
        chk("hold_pop", 32'(v), 32'h99);

        // reset in WAIT with 5 stored
        for (int i = 0; i < 5; i++) cap(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
        host_rd(1'b0, v);
        chk("pre_rst_pop", 32'(v), 32'h11);
        bus.rxrdy = 1'b1;
        bus.uart_data = 8'h66;
        repeat (2) @(negedge clk);
        chk("wait_cnt", 32'(bus.count), 32'd5);
        chk("wait_reads0", 32'(bus.reads0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cnt", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_dout", 32'(bus.dout), 32'h00);
        chk("mid_rst_irq", 32'(bus.irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("recap_ack", 32'(bus.reads0), 32'd1);
        chk("recap_cnt", 32'(bus.count), 32'd1);
        bus.rxrdy = 1'b0;
        repeat (2) @(negedge clk);
        host_rd(1'b0, v);
        chk("recap_pop", 32'(v), 32'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rxrdy  in  1  receive engine holds a completed byte; level, stays high until acknowledged.
REQ-005 uart_data  in  8  received byte, valid while rxrdy=1.
REQ-006 perr, ferr, ovf  in  1 each  engine error flags for the byte, valid while rxrdy=1.
REQ-007 reads0  out  1  one-cycle acknowledge pulse to the engine; clears its rxrdy and flags.
REQ-008 rd  in  1  host read strobe, one cycle per access.
REQ-009 addr  in  1  host register select: 0 = data (pop), 1 = status.
REQ-010 dout  out  8  registered host read data.
REQ-011 empty, full  out  1 each  FIFO occupancy flags.
REQ-012 count  out  DEPTH_LOG2+1  number of stored entries, 0..DEPTH.
REQ-013 irq  out  1  host interrupt request.

Function
REQ-014 Storage SHALL be DEPTH entries of 11 bits {ovf, ferr, perr, uart_data}, circular, with DEPTH_LOG2-bit read/write pointers wrapping DEPTH-1 -> 0.
REQ-015 Capture FSM SHALL have states IDLE, ACK, WAIT.
REQ-016 IDLE: on rxrdy=1 -> ACK; push sampled entry on that edge if not full.
REQ-017 ACK: reads0=1 for exactly this one cycle -> WAIT unconditionally.
REQ-018 WAIT: stay while rxrdy=1; rxrdy=0 -> IDLE; a byte SHALL never be captured twice.
REQ-019 reads0 SHALL be 0 in IDLE and WAIT.
REQ-020 Capture while full: entry discarded, pointers unchanged, sticky drop flag set, acknowledge still issued.
REQ-021 rd=1, addr=0, not empty: next cycle dout = data byte at head, read pointer advances, count decrements.
REQ-022 rd=1, addr=0, empty: dout = 8'h00 next cycle, no pointer or count change.
REQ-023 rd=1, addr=1: next cycle dout = {drop, head_ovf, head_ferr, head_perr, 2'b00, full, empty}; head_* = 0 when empty; drop cleared on same edge.
REQ-024 Drop set and status read on same edge: drop SHALL remain 1 (set wins).
REQ-025 Push and pop on same edge: both performed, count unchanged; when full, the pop frees space, push accepted.
REQ-026 Push and pop on same edge when empty: push accepted, pop treated as REQ-022, count becomes 1.
REQ-027 dout SHALL hold last value when rd=0.
REQ-028 empty = (count==0), full = (count==DEPTH), derived from registered count, no extra latency.
REQ-029 irq = ~empty | drop.
REQ-030 Total read latency: 1 clock from rd to dout valid; capture latency rxrdy to reads0: 1 clock.

Reset
REQ-031 rst=1 SHALL set FSM IDLE, pointers 0, count 0, drop 0, dout 8'h00, reads0 0; empty=1, full=0, irq=0.
REQ-032 rst mid-handshake (ACK or WAIT) SHALL abort to IDLE; stored contents discarded; a still-high rxrdy after reset is captured as new byte.
REQ-033 Memory array contents need no reset; unreadable until written.

Verification
REQ-034 Single byte: rxrdy=1, uart_data=8'hA5, flags 0 -> reads0 pulse 1 cycle later, count=1, irq=1; rd addr=0 -> dout=8'hA5, empty=1.
REQ-035 Error flags: capture 8'h3C with ferr=1, perr=1 -> status read dout=8'h30; pop dout=8'h3C; status read dout=8'h01.
REQ-036 Fill: 16 captures 8'h00..8'h0F -> full=1, count=16; 17th capture 8'hFF -> reads0 pulses, drop=1, status=8'h82; pops return 00..0F in order, FIFO never returns FF.
REQ-037 Wrap and simultaneous: keep 8 entries, 40 bytes with push and pop on same cycle -> count stays 8, order preserved across pointer wrap.
REQ-038 rxrdy held high 10 cycles -> exactly one push, one reads0 pulse.
REQ-039 rst asserted in WAIT with count=5 -> count=0, empty=1, dout=8'h00, irq=0 following cycle.
